// File: rtl/cmd_scheduler.sv
// Command scheduler: one UART frame -> one device request -> 2-byte UART response.
// Optional macro CMD_SCHED_CONTINUOUS_EN adds periodic re-issue (cmd 0x04) and stop (cmd 0x05).
module cmd_scheduler #(
    parameter int NUM_DEVICES    = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_done_i,
    input  logic [7:0] rx_address_i,
    input  logic [7:0] rx_command_i,
    output logic       dev_start_o,
    output logic [7:0] dev_sel_o,
    output logic [7:0] dev_cmd_o,
    input  logic       dev_done_i,
    input  logic       dev_error_i,
    input  logic [7:0] dev_data_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_done_i,
    output logic       busy_o,
    output logic       overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REQUEST, S_WAIT_DEV,
        S_SEND_B0, S_WAIT_TX0, S_SEND_B1, S_WAIT_TX1
    } state_t;

`ifdef CMD_SCHED_CONTINUOUS_EN
    localparam logic [7:0] MAX_CMD  = 8'h05;
    localparam logic [7:0] CMD_CONT = 8'h04;
    localparam logic [7:0] CMD_STOP = 8'h05;
`else
    localparam logic [7:0] MAX_CMD  = 8'h03;
`endif
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic             dev_start_q;
    logic [7:0]       dev_sel_q;
    logic [7:0]       dev_cmd_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic [7:0]       byte1_q;
    logic             busy_q;
    logic             overrun_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             addr_ok;
    logic             cmd_ok;
`ifdef CMD_SCHED_CONTINUOUS_EN
    logic             cont_q;
`endif

    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        addr_ok = ({24'd0, dev_sel_q} < 32'(NUM_DEVICES));
        cmd_ok  = (dev_cmd_q <= MAX_CMD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            dev_start_q <= 1'b0;
            dev_sel_q   <= 8'h00;
            dev_cmd_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            byte1_q     <= 8'h00;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef CMD_SCHED_CONTINUOUS_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            dev_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            // Only IDLE accepts frames; anything arriving later is dropped and flagged.
            if (rx_done_i && state_q != S_IDLE)
                overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (rx_done_i) begin
                        dev_sel_q <= rx_address_i;
                        dev_cmd_q <= rx_command_i;
                        busy_q    <= 1'b1;
                        state_q   <= S_CHECK;
                    end
`ifdef CMD_SCHED_CONTINUOUS_EN
                    else if (cont_q) begin
                        if (cnt_q == TO_LAST) begin
                            dev_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_REQUEST;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
`endif
                end

                S_CHECK: begin
`ifdef CMD_SCHED_CONTINUOUS_EN
                    cont_q <= 1'b0;
`endif
                    if (!addr_ok) begin
                        tx_data_q  <= 8'hE1;
                        byte1_q    <= 8'h00;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B0;
                    end else if (!cmd_ok) begin
                        tx_data_q  <= 8'hE2;
                        byte1_q    <= 8'h00;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B0;
                    end
`ifdef CMD_SCHED_CONTINUOUS_EN
                    else if (dev_cmd_q == CMD_STOP) begin
                        tx_data_q  <= 8'h00;
                        byte1_q    <= 8'h00;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B0;
                    end
`endif
                    else begin
`ifdef CMD_SCHED_CONTINUOUS_EN
                        cont_q      <= (dev_cmd_q == CMD_CONT);
`endif
                        dev_start_q <= 1'b1;
                        state_q     <= S_REQUEST;
                    end
                end

                S_REQUEST: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_DEV;
                end

                S_WAIT_DEV: begin
                    // A reply on the final timeout cycle still counts as a reply.
                    if (dev_done_i) begin
                        tx_data_q  <= dev_error_i ? 8'hE4 : 8'h00;
                        byte1_q    <= dev_error_i ? 8'h00 : dev_data_i;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B0;
                    end else if (cnt_q == TO_LAST) begin
                        tx_data_q  <= 8'hE3;
                        byte1_q    <= 8'h00;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_SEND_B0: state_q <= S_WAIT_TX0;

                S_WAIT_TX0: begin
                    if (tx_done_i) begin
                        tx_data_q  <= byte1_q;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_B1;
                    end
                end

                S_SEND_B1: state_q <= S_WAIT_TX1;

                S_WAIT_TX1: begin
                    if (tx_done_i) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dev_start_o = dev_start_q;
    assign dev_sel_o   = dev_sel_q;
    assign dev_cmd_o   = dev_cmd_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed frames, reset abort and a randomized frame loop
// checked against a response model built from the frame rules.
module tb_cmd_scheduler;

`ifdef CMD_SCHED_CONTINUOUS_EN
    localparam int T       = 50;
    localparam int MAX_CMD = 5;
`else
    localparam int T       = 100;
    localparam int MAX_CMD = 3;
`endif
    localparam int NDEV = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_address, rx_command;
    logic       dev_start;
    logic [7:0] dev_sel, dev_cmd;
    logic       dev_done, dev_error;
    logic [7:0] dev_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy, overrun;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cmd_scheduler #(
        .NUM_DEVICES   (NDEV),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (26)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_done_i   (rx_done),
        .rx_address_i(rx_address),
        .rx_command_i(rx_command),
        .dev_start_o (dev_start),
        .dev_sel_o   (dev_sel),
        .dev_cmd_o   (dev_cmd),
        .dev_done_i  (dev_done),
        .dev_error_i (dev_error),
        .dev_data_i  (dev_data),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_done_i   (tx_done),
        .busy_o      (busy),
        .overrun_o   (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {status, byte1} for a frame; mode 0 = device answers, 1 = device error, 2 = silent.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] c,
                                          input int mode, input logic [7:0] data);
        if (int'(a) >= NDEV)           return {8'hE1, 8'h00};
        if (int'(c) > MAX_CMD)         return {8'hE2, 8'h00};
        if (MAX_CMD == 5 && c == 8'h05) return {8'h00, 8'h00};
        case (mode)
            0:       return {8'h00, data};
            1:       return {8'hE4, 8'h00};
            default: return {8'hE3, 8'h00};
        endcase
    endfunction

    task automatic serve_dev(input int mode, input int d, input logic [7:0] data);
        int k = 0;
        if (mode != 2) begin
            repeat (d) begin tick(); k++; end
            dev_done  = 1'b1;
            dev_error = (mode == 1);
            dev_data  = data;
            tick(); k++;
            dev_done  = 1'b0;
            dev_error = 1'($urandom);
            dev_data  = 8'($urandom);
        end
        while (!tx_start && k < T + 20) begin tick(); k++; end
        chk("dev_to_tx_cycles", k, (mode == 2) ? T + 1 : d + 1);
    endtask

    // inject 1: stray rx_done in WAIT_TX0; inject 2: rx_done together with tx_done.
    task automatic recv_byte(input logic [7:0] exp, input string tag, input int inject);
        int n = 0;
        int w;
        while (!tx_start && n < 20) begin tick(); n++; end
        chk({tag, "_start"}, tx_start, 1);
        chk(tag, tx_data, exp);
        w = $urandom_range(2, 5);
        for (int i = 0; i < w; i++) begin
            if (inject == 1 && i == w - 1) begin
                rx_done = 1'b1; rx_address = 8'h01; rx_command = 8'h01;
            end
            tick();
            rx_done = 1'b0;
        end
        chk({tag, "_hold"}, tx_data, exp);
        tx_done = 1'b1;
        if (inject == 2) begin
            rx_done = 1'b1; rx_address = 8'h02; rx_command = 8'h00;
        end
        tick();
        tx_done = 1'b0;
        rx_done = 1'b0;
    endtask

    task automatic recv_pair(input logic [15:0] exp, input int inject);
        recv_byte(exp[15:8], "tx_b0", (inject == 1) ? 1 : 0);
        recv_byte(exp[7:0],  "tx_b1", (inject == 2) ? 2 : 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input int mode,
                             input int d, input logic [7:0] data, input int inject);
        logic [15:0] exp;
        bit          exp_dev;
        int          n = 0;
        exp     = model(a, c, mode, data);
        exp_dev = (int'(a) < NDEV) && (int'(c) <= MAX_CMD) && !(MAX_CMD == 5 && c == 8'h05);
        rx_address = a; rx_command = c; rx_done = 1'b1;
        tick();
        rx_done = 1'b0; rx_address = 8'($urandom); rx_command = 8'($urandom);
        chk("busy_on_accept", busy, 1);
        while (!dev_start && !tx_start && n < 10) begin tick(); n++; end
        chk("rx_to_first_pulse", n + 1, 2);
        chk("dev_start_taken", dev_start, exp_dev);
        if (exp_dev && dev_start) begin
            chk("dev_sel", dev_sel, a);
            chk("dev_cmd", dev_cmd, c);
            serve_dev(mode, d, data);
        end
        recv_pair(exp, inject);
        $display("frame addr=%02h cmd=%02h mode=%0d -> expect %04h", a, c, mode, exp);
    endtask

    task automatic idle_quiet(input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (busy || dev_start || tx_start) seen++;
        end
        chk("idle_quiet", seen, 0);
    endtask

    initial begin
        int n;
        logic [7:0] ra, rc;
        rst_n = 1'b0; rx_done = 1'b0; rx_address = 8'h00; rx_command = 8'h00;
        dev_done = 1'b0; dev_error = 1'b0; dev_data = 8'h00; tx_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_dev_start", dev_start, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dev_sel", dev_sel, 0);
        chk("rst_dev_cmd", dev_cmd, 0);
        chk("rst_tx_data", tx_data, 0);

        run_frame(8'h03, 8'h01, 0, 2, 8'h5A, 0);
        run_frame(8'h20, 8'h09, 0, 1, 8'h00, 0);
        run_frame(8'h05, 8'h02, 2, 0, 8'h00, 0);
`ifdef CMD_SCHED_CONTINUOUS_EN
        run_frame(8'h03, 8'h04, 0, 3, 8'h3C, 0);
        n = 0;
        while (!dev_start && n < T + 10) begin tick(); n++; end
        chk("cont_period", n, T);
        chk("cont_sel", dev_sel, 8'h03);
        serve_dev(0, 2, 8'h77);
        recv_pair({8'h00, 8'h77}, 0);
        run_frame(8'h03, 8'h05, 0, 1, 8'h00, 0);
        idle_quiet(T + 10);
`else
        run_frame(8'h03, 8'h04, 0, 2, 8'h11, 0);
`endif
        chk("overrun_clear", overrun, 0);

        run_frame(8'h07, 8'h00, 1, 3, 8'hAB, 2);
        idle_quiet(4);
        chk("overrun_at_exit", overrun, 1);
        run_frame(8'h09, 8'h03, 1, 1, 8'h00, 1);
        idle_quiet(4);
        chk("overrun_sticky", overrun, 1);

        // Abort a transaction in WAIT_DEV with an asynchronous reset.
        rx_address = 8'h04; rx_command = 8'h02; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        n = 0;
        while (!dev_start && n < 10) begin tick(); n++; end
        chk("abort_dev_start", dev_start, 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_overrun", overrun, 0);
        chk("async_dev_sel", dev_sel, 0);
        chk("async_dev_cmd", dev_cmd, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_tx_start", tx_start, 0);
        tick(); tick();
        rst_n = 1'b1;
        idle_quiet(T + 5);
        run_frame(8'h00, 8'h00, 0, 1, 8'hC3, 0);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom_range(0, 40));
            rc = 8'($urandom_range(0, 7));
            if (MAX_CMD == 5 && rc == 8'h04) rc = 8'h02;
            run_frame(ra, rc, $urandom_range(0, 2), $urandom_range(1, 8), 8'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
